// File: rtl/alarm_clk_pkg.sv
// Shared types for the alarm clock front panel: hold-tracker states, the button event
// record, and the depth of the per-button sample filter.
package alarm_clk_pkg;

    localparam int FILT_DEPTH = 3;
    localparam int EVT_ID_W   = 8;

    typedef enum logic [1:0] {
        TRK_IDLE,
        TRK_HOLD,
        TRK_WAIT,
        TRK_REPEAT
    } trk_state_t;

    typedef struct packed {
        logic [EVT_ID_W-1:0] id;
        logic                long;
    } btn_evt_t;

endpackage

// File: rtl/btn_sample_filter.sv
// One button: two-flop synchroniser into a FILT_DEPTH-deep sample shift register loaded on
// sample_tick. The level is the AND of all samples (slow rise, immediate fall).
module btn_sample_filter
    import alarm_clk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sample_tick,
    input  logic btn_raw,
    output logic btn_level
);

    logic [1:0]            sync_q, sync_d;
    logic [FILT_DEPTH-1:0] shift_q, shift_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        shift_d = shift_q;
        if (sample_tick) begin
            shift_d = {shift_q[FILT_DEPTH-2:0], sync_q[1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= sync_d;
            shift_q <= shift_d;
        end
    end

    assign btn_level = &shift_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Front-panel button controller: filtered levels, press-edge pending bits, fixed-priority
// event arbiter with a valid/ready output register, and a single long-hold tracker.
// Build option: define BTN_AUTOREPEAT_EN to add periodic long events while a button is held.
module button_event_ctrl
    import alarm_clk_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int CLK_HZ       = 100000000,
    parameter int SAMPLE_HZ    = 200,
    parameter int HOLD_TICKS   = 100,
    parameter int REPEAT_TICKS = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    input  logic                     evt_ready,
    output logic [N_BTN-1:0]         btn_level
);

    localparam int ID_W     = $clog2(N_BTN);
    localparam int TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam int CNT_MAX  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int CNT_W    = $clog2(CNT_MAX);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic             sample_tick;
    logic [N_BTN-1:0] level_prev_q, level_prev_d;
    logic [N_BTN-1:0] pend_q, pend_d, pend_long_q, pend_long_d;
    logic [N_BTN-1:0] rise, clr_short, clr_long, long_set;
    logic             evt_valid_q, evt_valid_d;
    btn_evt_t         evt_q, evt_d;
    trk_state_t       trk_q, trk_d;
    logic [ID_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_hit, long_hit, load, lvl_k, acc_lvl, accept_short;
    logic [ID_W-1:0]  short_idx, long_idx;
    logic             unused_id_hi;

    assign sample_tick = (presc_q == PRE_W'(TICK_DIV - 1));
    assign presc_d     = sample_tick ? '0 : presc_q + 1'b1;

    for (genvar i = 0; i < N_BTN; i++) begin : g_filt
        btn_sample_filter u_filt (
            .clk         (clk),
            .reset       (reset),
            .sample_tick (sample_tick),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i])
        );
    end

    assign level_prev_d = btn_level;
    assign rise         = btn_level & ~level_prev_q;

    // Lowest index wins inside each kind; the descending scan leaves the lowest hit last.
    always_comb begin
        short_hit = |pend_q;
        long_hit  = |pend_long_q;
        short_idx = '0;
        long_idx  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i])      short_idx = ID_W'(i);
            if (pend_long_q[i]) long_idx  = ID_W'(i);
        end
    end

    always_comb begin
        load        = ~evt_valid_q | evt_ready;
        evt_valid_d = evt_valid_q;
        evt_d       = evt_q;
        clr_short   = '0;
        clr_long    = '0;
        if (load) begin
            evt_valid_d = short_hit | long_hit;
            if (long_hit) begin
                evt_d.id           = EVT_ID_W'(long_idx);
                evt_d.long         = 1'b1;
                clr_long[long_idx] = 1'b1;
            end else if (short_hit) begin
                evt_d.id             = EVT_ID_W'(short_idx);
                evt_d.long           = 1'b0;
                clr_short[short_idx] = 1'b1;
            end
        end
        // A set arriving in the same cycle as the clear keeps the bit pending.
        pend_d      = (pend_q & ~clr_short) | rise;
        pend_long_d = (pend_long_q & ~clr_long) | long_set;
    end

    always_comb begin
        trk_d        = trk_q;
        k_d          = k_q;
        cnt_d        = cnt_q;
        long_set     = '0;
        lvl_k        = 1'b0;
        acc_lvl      = 1'b0;
        accept_short = evt_valid_q & evt_ready & ~evt_q.long;
        for (int i = 0; i < N_BTN; i++) begin
            if (k_q == ID_W'(i))                  lvl_k   = btn_level[i];
            if (evt_q.id[ID_W-1:0] == ID_W'(i))   acc_lvl = btn_level[i];
        end
        case (trk_q)
            TRK_IDLE: begin
                if (accept_short && acc_lvl) begin
                    trk_d = TRK_HOLD;
                    k_d   = evt_q.id[ID_W-1:0];
                    cnt_d = '0;
                end
            end
            TRK_HOLD: begin
                if (!lvl_k) begin
                    trk_d = TRK_IDLE;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
                        long_set[k_q] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        trk_d = TRK_REPEAT;
                        cnt_d = '0;
`else
                        trk_d = TRK_WAIT;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            TRK_WAIT: begin
                if (!lvl_k) trk_d = TRK_IDLE;
            end
`ifdef BTN_AUTOREPEAT_EN
            TRK_REPEAT: begin
                if (!lvl_k) begin
                    trk_d = TRK_IDLE;
                end else if (sample_tick) begin
                    if (cnt_q == CNT_W'(REPEAT_TICKS - 1)) begin
                        long_set[k_q] = 1'b1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            default: trk_d = TRK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q      <= '0;
            level_prev_q <= '0;
            pend_q       <= '0;
            pend_long_q  <= '0;
            evt_valid_q  <= 1'b0;
            evt_q        <= '0;
            trk_q        <= TRK_IDLE;
            k_q          <= '0;
            cnt_q        <= '0;
        end else begin
            presc_q      <= presc_d;
            level_prev_q <= level_prev_d;
            pend_q       <= pend_d;
            pend_long_q  <= pend_long_d;
            evt_valid_q  <= evt_valid_d;
            evt_q        <= evt_d;
            trk_q        <= trk_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
        end
    end

    assign evt_valid    = evt_valid_q;
    assign evt_id       = evt_q.id[ID_W-1:0];
    assign evt_long     = evt_q.long;
    assign unused_id_hi = ^evt_q.id[EVT_ID_W-1:ID_W];

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: a sample tick every 10 clocks, hold = 4 ticks,
// repeat = 2 ticks. Raw inputs change mid-way between sample ticks.
module tb_button_event_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn_raw = '0;
    logic       evt_valid;
    logic [2:0] evt_id;
    logic       evt_long;
    logic       evt_ready = 1'b1;
    logic [4:0] btn_level;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .N_BTN(5), .CLK_HZ(1000), .SAMPLE_HZ(100), .HOLD_TICKS(4), .REPEAT_TICKS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_long  (evt_long),
        .evt_ready (evt_ready),
        .btn_level (btn_level)
    );

    typedef struct { int id; int lng; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   acc_id[$], acc_long[$], acc_cyc[$];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, base = 0, idx = 0, gap = 0, cnt0 = 0;
    int   vld_rise_cyc = 0;
    int   lvl_rise_cyc[5];
    bit   allow_rep4 = 1'b0;
    bit   prev_vld = 1'b0, prev_rdy = 1'b1;
    int   prev_id = 0, prev_long = 0;
    logic [4:0] prev_lvl = '0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int id, input int lng);
        exp_t e;
        e.id  = id;
        e.lng = lng;
        exp_q.push_back(e);
    endtask

    // Advance to the next point half-way between sample ticks.
    task automatic tick_step();
        for (int g = 0; g < 20; g++) begin
            @(posedge clk);
            #1;
            if (((cyc - base) % 10) == 5) break;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick_step();
    endtask

    function automatic int gap_at(input int a);
        if (acc_cyc.size() > a + 1) return acc_cyc[a+1] - acc_cyc[a];
        return -1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_vld = 1'b0;
            prev_rdy = 1'b1;
            prev_lvl = '0;
        end else begin
            if (evt_valid && !prev_vld) vld_rise_cyc = cyc;
            for (int i = 0; i < 5; i++)
                if (btn_level[i] && !prev_lvl[i]) lvl_rise_cyc[i] = cyc;
            if (prev_vld && !prev_rdy) begin
                check_eq("stall_valid", int'(evt_valid), 1);
                check_eq("stall_id", int'(evt_id), prev_id);
                check_eq("stall_long", int'(evt_long), prev_long);
            end
            if (evt_valid && evt_ready) begin
                acc_id.push_back(int'(evt_id));
                acc_long.push_back(int'(evt_long));
                acc_cyc.push_back(cyc);
                if (!(allow_rep4 && evt_id == 3'd4 && evt_long)) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_evt_id", int'(evt_id), -1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("evt_id", int'(evt_id), mon_e.id);
                        check_eq("evt_long", int'(evt_long), mon_e.lng);
                    end
                end
            end
            prev_vld  = evt_valid;
            prev_rdy  = evt_ready;
            prev_id   = int'(evt_id);
            prev_long = int'(evt_long);
            prev_lvl  = btn_level;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", int'(evt_valid), 0);
        check_eq("rst_id", int'(evt_id), 0);
        check_eq("rst_long", int'(evt_long), 0);
        check_eq("rst_level", int'(btn_level), 0);
        reset = 1'b0;
        base  = cyc;

        // 1: samples 1,0,1,1,1 on btn0
        tick_step();
        idx = acc_id.size();
        push_exp(0, 0);
        btn_raw[0] = 1'b1; tick_step();
        btn_raw[0] = 1'b0; tick_step();
        btn_raw[0] = 1'b1; ticks(2);
        check_eq("t1_level_after_4_samples", int'(btn_level[0]), 0);
        tick_step();
        check_eq("t1_level_after_3_ones", int'(btn_level[0]), 1);
        check_eq("t1_latency", vld_rise_cyc - lvl_rise_cyc[0], 2);
        btn_raw[0] = 1'b0; tick_step();
        check_eq("t1_level_fall", int'(btn_level[0]), 0);
        ticks(3);
        check_eq("t1_evt_count", acc_id.size() - idx, 1);
        check_eq("t1_queue_empty", exp_q.size(), 0);

        // 2: btn1 and btn3 together
        idx = acc_id.size();
        push_exp(1, 0);
        push_exp(3, 0);
        btn_raw[1] = 1'b1; btn_raw[3] = 1'b1; ticks(4);
        btn_raw[1] = 1'b0; btn_raw[3] = 1'b0; ticks(3);
        check_eq("t2_evt_count", acc_id.size() - idx, 2);
        check_eq("t2_consecutive", gap_at(idx), 1);
        check_eq("t2_queue_empty", exp_q.size(), 0);

        // 3: stalled consumer, btn2 pressed twice
        evt_ready = 1'b0;
        idx = acc_id.size();
        push_exp(2, 0);
        push_exp(2, 0);
        btn_raw[2] = 1'b1; ticks(3);
        btn_raw[2] = 1'b0; ticks(1);
        btn_raw[2] = 1'b1; ticks(3);
        check_eq("t3_valid_held", int'(evt_valid), 1);
        check_eq("t3_id_held", int'(evt_id), 2);
        check_eq("t3_long_held", int'(evt_long), 0);
        check_eq("t3_none_accepted", acc_id.size() - idx, 0);
        evt_ready = 1'b1;
        tick_step();
        btn_raw[2] = 1'b0; ticks(3);
        check_eq("t3_evt_count", acc_id.size() - idx, 2);
        check_eq("t3_queue_empty", exp_q.size(), 0);

        // 4: btn4 held for 10 ticks
        idx = acc_id.size();
        push_exp(4, 0);
        push_exp(4, 1);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(4, 1);
        push_exp(4, 1);
`endif
        btn_raw[4] = 1'b1; ticks(10);
        btn_raw[4] = 1'b0; ticks(4);
        check_eq("t4_short_to_long", gap_at(idx), 39);
`ifdef BTN_AUTOREPEAT_EN
        check_eq("t4_evt_count", acc_id.size() - idx, 4);
        check_eq("t4_repeat_gap1", gap_at(idx + 1), 20);
        check_eq("t4_repeat_gap2", gap_at(idx + 2), 20);
`else
        check_eq("t4_evt_count", acc_id.size() - idx, 2);
`endif
        check_eq("t4_queue_empty", exp_q.size(), 0);

        // 5: reset while tracking btn4, button held through reset
        push_exp(4, 0);
        btn_raw[4] = 1'b1; ticks(5);
        reset = 1'b1;
        #1;
        check_eq("t5_rst_valid", int'(evt_valid), 0);
        check_eq("t5_rst_id", int'(evt_id), 0);
        check_eq("t5_rst_long", int'(evt_long), 0);
        check_eq("t5_rst_level", int'(btn_level), 0);
        check_eq("t5_pre_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
        idx = acc_id.size();
        push_exp(4, 0);
        push_exp(4, 1);
`ifdef BTN_AUTOREPEAT_EN
        push_exp(4, 1);
`endif
        ticks(10);
        btn_raw[4] = 1'b0; ticks(4);
        check_eq("t5_short_time", (acc_cyc.size() > idx) ? acc_cyc[idx] - base : -1, 32);
        check_eq("t5_short_to_long", gap_at(idx), 39);
`ifdef BTN_AUTOREPEAT_EN
        check_eq("t5_repeat_gap", gap_at(idx + 1), 20);
        check_eq("t5_evt_count", acc_id.size() - idx, 3);
`else
        check_eq("t5_evt_count", acc_id.size() - idx, 2);
`endif
        check_eq("t5_queue_empty", exp_q.size(), 0);

        // 6: btn0 pressed while btn4 is past its long event
        idx = acc_id.size();
        push_exp(4, 0);
`ifdef BTN_AUTOREPEAT_EN
        allow_rep4 = 1'b1;
`else
        push_exp(4, 1);
`endif
        push_exp(0, 0);
        btn_raw[4] = 1'b1; ticks(8);
        btn_raw[0] = 1'b1; ticks(8);
        btn_raw[0] = 1'b0; btn_raw[4] = 1'b0; ticks(4);
        allow_rep4 = 1'b0;
        cnt0 = 0;
        for (int i = idx; i < acc_id.size(); i++)
            if (acc_id[i] == 0) cnt0++;
        check_eq("t6_btn0_evt_count", cnt0, 1);
`ifndef BTN_AUTOREPEAT_EN
        check_eq("t6_evt_count", acc_id.size() - idx, 3);
`endif
        check_eq("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
